// File: rtl/micro_sequencer.sv
// micro_sequencer
//   Microprogram sequencer for the T11 control store. Every cycle it forms
//   the next 9-bit microaddress for the microcode ROM (which registers it)
//   from the flow field of the executing microword, the IR, the Z flag and
//   bus-ready, and it owns the microcode return-address stack.
//
//   Optional feature macro: USEQ_TRAP_EN
//     defined   : CIP on an undecoded IR pushes upc+1, jumps to TRAP_VEC and
//                 pulses ill_op.
//     undefined : CIP on an undecoded IR refetches via RESET_VEC with no push;
//                 ill_op stays 0.
//
//   Ports
//     clk        in   system clock, all state changes on posedge
//     reset_n    in   synchronous active-low reset
//     uflow      in   flow field: 0 NEXT 1 JMP 2 RET 3 CIP 4 CSD 5 CDD 6 JZ 7 JNZ
//     ufield     in   address field of the current microword
//     ir         in   instruction register
//     zf         in   Z condition flag
//     rdy        in   0 stalls the current microword
//     uaddr      out  next microaddress (combinational) to the ROM
//     upc        out  address of the microword on the ROM output
//     uvalid     out  ROM output valid and executing
//     stk_depth  out  call-stack occupancy
//     stk_err    out  sticky overflow/underflow flag
//     ill_op     out  one-cycle pulse on CIP with undecoded IR (trap build)
module micro_sequencer #(
    parameter int         STACK_DEPTH = 4,
    parameter logic [8:0] RESET_VEC   = 9'h000,
    parameter logic [8:0] TRAP_VEC    = 9'h1ff
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [2:0]                   uflow,
    input  logic [8:0]                   ufield,
    input  logic [15:0]                  ir,
    input  logic                         zf,
    input  logic                         rdy,
    output logic [8:0]                   uaddr,
    output logic [8:0]                   upc,
    output logic                         uvalid,
    output logic [$clog2(STACK_DEPTH):0] stk_depth,
    output logic                         stk_err,
    output logic                         ill_op
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

`ifdef USEQ_TRAP_EN
    localparam logic TRAP_ON = 1'b1;
`else
    localparam logic TRAP_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        FL_NEXT = 3'd0,
        FL_JMP  = 3'd1,
        FL_RET  = 3'd2,
        FL_CIP  = 3'd3,
        FL_CSD  = 3'd4,
        FL_CDD  = 3'd5,
        FL_JZ   = 3'd6,
        FL_JNZ  = 3'd7
    } flow_t;

    logic [8:0]    upc_reg;
    logic          uvalid_reg;
    logic [DW-1:0] depth_reg;
    logic          err_reg;
    logic [8:0]    stack_mem [STACK_DEPTH];

    flow_t         flow;
    logic [8:0]    seq_addr;
    logic [8:0]    uaddr_next;
    logic [8:0]    top_entry;
    logic [DW-1:0] depth_dec;
    logic          stack_full;
    logic          stack_empty;
    logic          push_req;
    logic          pop_req;
    logic          do_push;
    logic          ret_underflow;
    logic          set_err;
    logic          ill_next;
    logic          dec_hit;
    logic [8:0]    dec_vec;
    logic          unused_ir_bits;

    assign flow        = flow_t'(uflow);
    assign seq_addr    = upc_reg + 9'd1;   // wraps 1ff -> 000
    assign depth_dec   = depth_reg - DW'(1);
    assign top_entry   = stack_mem[depth_dec[PW-1:0]];
    assign stack_full  = (depth_reg == DW'(STACK_DEPTH));
    assign stack_empty = (depth_reg == '0);

    // Register field of the source/destination specifier is not needed here.
    assign unused_ir_bits = ^ir[2:0];

    // Instruction entry decode for CIP; the three patterns are disjoint.
    always_comb begin
        dec_hit = 1'b1;
        dec_vec = RESET_VEC;
        if (ir[15:8] == 8'h02)
            dec_vec = 9'h008;                  // BNE
        else if (ir[15:6] == 10'b0000101011)
            dec_vec = 9'h028;                  // DEC
        else if (ir[15:12] == 4'b0001)
            dec_vec = 9'h040;                  // MOV
        else
            dec_hit = 1'b0;
    end

    always_comb begin
        uaddr_next    = RESET_VEC;
        push_req      = 1'b0;
        pop_req       = 1'b0;
        ret_underflow = 1'b0;
        ill_next      = 1'b0;
        if (!reset_n || !uvalid_reg) begin
            uaddr_next = RESET_VEC;
        end else if (!rdy) begin
            uaddr_next = upc_reg;              // ROM re-presents the stalled word
        end else begin
            case (flow)
                FL_NEXT: uaddr_next = seq_addr;
                FL_JMP:  uaddr_next = ufield;
                FL_JZ:   uaddr_next = zf ? ufield : seq_addr;
                FL_JNZ:  uaddr_next = zf ? seq_addr : ufield;
                FL_RET: begin
                    if (stack_empty) begin
                        uaddr_next    = RESET_VEC;
                        ret_underflow = 1'b1;
                    end else begin
                        uaddr_next = top_entry;
                        pop_req    = 1'b1;
                    end
                end
                FL_CIP: begin
                    if (dec_hit) begin
                        uaddr_next = dec_vec;
                        push_req   = 1'b1;
                    end else if (TRAP_ON) begin
                        uaddr_next = TRAP_VEC;
                        push_req   = 1'b1;
                        ill_next   = 1'b1;
                    end else begin
                        uaddr_next = RESET_VEC;    // skip the instruction
                    end
                end
                FL_CSD: begin
                    uaddr_next = 9'h100 + {1'b0, ir[11:9], 5'b0};
                    push_req   = 1'b1;
                end
                FL_CDD: begin
                    uaddr_next = 9'h110 + {1'b0, ir[5:3], 5'b0};
                    push_req   = 1'b1;
                end
                default: uaddr_next = seq_addr;
            endcase
        end
    end

    // A push into a full stack is dropped but the jump still happens.
    assign do_push = push_req && !stack_full;
    assign set_err = (push_req && stack_full) || ret_underflow;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            upc_reg    <= RESET_VEC;
            uvalid_reg <= 1'b0;
            depth_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            uvalid_reg <= 1'b1;
            if (uvalid_reg)
                upc_reg <= uaddr_next;
            if (do_push)
                depth_reg <= depth_reg + DW'(1);
            else if (pop_req)
                depth_reg <= depth_dec;
            if (set_err)
                err_reg <= 1'b1;
        end
    end

    // Stack storage needs no reset: occupancy alone defines valid entries.
    always_ff @(posedge clk) begin
        if (reset_n && do_push)
            stack_mem[depth_reg[PW-1:0]] <= seq_addr;
    end

    assign uaddr     = uaddr_next;
    assign upc       = upc_reg;
    assign uvalid    = uvalid_reg;
    assign stk_depth = depth_reg;
    assign stk_err   = err_reg;
    assign ill_op    = ill_next;

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: a small microcode ROM model indexed by upc
// feeds uflow/ufield; directed scenarios check traces against hand tables.
module tb_micro_sequencer;

    localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, RET = 3'd2, CIP = 3'd3,
                           CSD = 3'd4, CDD = 3'd5, JZ = 3'd6, JNZ = 3'd7;

    logic       clk;
    logic       reset_n;
    logic [2:0] uflow;
    logic [8:0] ufield;
    logic [15:0] ir;
    logic       zf;
    logic       rdy;
    logic [8:0] uaddr;
    logic [8:0] upc;
    logic       uvalid;
    logic [2:0] stk_depth;
    logic       stk_err;
    logic       ill_op;

    logic [2:0] rom_flow  [512];
    logic [8:0] rom_field [512];

    int n_cmp;
    int n_bad;

    micro_sequencer dut (
        .clk(clk), .reset_n(reset_n), .uflow(uflow), .ufield(ufield),
        .ir(ir), .zf(zf), .rdy(rdy), .uaddr(uaddr), .upc(upc),
        .uvalid(uvalid), .stk_depth(stk_depth), .stk_err(stk_err),
        .ill_op(ill_op)
    );

    assign uflow  = rom_flow[upc];
    assign ufield = rom_field[upc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_program();
        for (int i = 0; i < 512; i++) begin
            rom_flow[i]  = JMP;
            rom_field[i] = 9'h000;
        end
        rom_flow[9'h000] = NEXT;
        rom_flow[9'h001] = NEXT;
        rom_flow[9'h002] = CIP;
        rom_flow[9'h003] = JMP;  rom_field[9'h003] = 9'h000;
        rom_flow[9'h008] = JZ;   rom_field[9'h008] = 9'h00e;
        rom_flow[9'h009] = RET;
        rom_flow[9'h00e] = RET;
        rom_flow[9'h028] = RET;
        rom_flow[9'h040] = CSD;
        rom_flow[9'h041] = CDD;
        rom_flow[9'h042] = RET;
        rom_flow[9'h100] = RET;
        rom_flow[9'h110] = RET;
        rom_flow[9'h140] = NEXT;
        rom_flow[9'h141] = NEXT;
        rom_flow[9'h142] = RET;
        rom_flow[9'h1ff] = RET;
    endtask

    // Leaves the bench at the negedge just after release (uvalid still 0).
    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        load_program();
        ir = 16'h0000; zf = 1'b0; rdy = 1'b1;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (uaddr !== 9'h000 || uvalid !== 1'b0 || stk_depth !== 3'd0 || stk_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold c%0d: uaddr=%h uvalid=%b depth=%0d err=%b want 000/0/0/0",
                         c, uaddr, uvalid, stk_depth, stk_err);
            end
        end
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (uaddr !== 9'h000 || uvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first: uaddr=%h uvalid=%b want 000/0", uaddr, uvalid);
        end
        @(negedge clk);
        n_cmp++;
        if (uvalid !== 1'b1 || upc !== 9'h000 || stk_depth !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_valid: uvalid=%b upc=%h depth=%0d want 1/000/0", uvalid, upc, stk_depth);
        end
        $display("reset: done");
    endtask

    task automatic test_mov();
        logic [8:0] e_upc [10];
        logic [2:0] e_dep [10];
        e_upc = '{9'h000, 9'h001, 9'h002, 9'h040, 9'h100, 9'h041, 9'h110, 9'h042, 9'h003, 9'h000};
        e_dep = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0};
        load_program();
        ir = 16'o010102; zf = 1'b0; rdy = 1'b1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (upc !== e_upc[i] || stk_depth !== e_dep[i] || stk_err !== 1'b0) begin
                n_bad++;
                $display("FAIL mov_step%0d: upc=%h depth=%0d err=%b want %h/%0d/0",
                         i, upc, stk_depth, stk_err, e_upc[i], e_dep[i]);
            end
        end
        $display("mov: trace of 10 microwords checked");
    endtask

    task automatic test_autoinc_stall();
        logic [8:0] e_upc [6];
        logic [2:0] e_dep [6];
        e_upc = '{9'h000, 9'h001, 9'h002, 9'h040, 9'h140, 9'h141};
        e_dep = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
        load_program();
        ir = 16'o012102; zf = 1'b0; rdy = 1'b1;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (upc !== e_upc[i] || stk_depth !== e_dep[i]) begin
                n_bad++;
                $display("FAIL autoinc_step%0d: upc=%h depth=%0d want %h/%0d",
                         i, upc, stk_depth, e_upc[i], e_dep[i]);
            end
        end
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (uaddr !== 9'h141 || upc !== 9'h141 || stk_depth !== 3'd2) begin
                n_bad++;
                $display("FAIL stall%0d: uaddr=%h upc=%h depth=%0d want 141/141/2",
                         k, uaddr, upc, stk_depth);
            end
            @(negedge clk);
        end
        rdy = 1'b1;
        #1;
        n_cmp++;
        if (uaddr !== 9'h142) begin
            n_bad++;
            $display("FAIL stall_resume: uaddr=%h want 142", uaddr);
        end
        @(negedge clk);
        n_cmp++;
        if (upc !== 9'h142) begin
            n_bad++;
            $display("FAIL autoinc_142: upc=%h want 142", upc);
        end
        @(negedge clk);
        n_cmp++;
        if (upc !== 9'h041 || stk_depth !== 3'd1) begin
            n_bad++;
            $display("FAIL autoinc_ret: upc=%h depth=%0d want 041/1", upc, stk_depth);
        end
        $display("autoinc/stall: done");
    endtask

    task automatic test_dispatch();
        logic [15:0] s_ir [3];
        logic        s_zf [3];
        logic [8:0]  e_upc [3][6];
        logic [2:0]  e_dep [3][6];
        s_ir  = '{16'h0205, 16'h0205, 16'h0AC0};
        s_zf  = '{1'b1, 1'b0, 1'b0};
        e_upc = '{'{9'h000, 9'h001, 9'h002, 9'h008, 9'h00e, 9'h003},
                  '{9'h000, 9'h001, 9'h002, 9'h008, 9'h009, 9'h003},
                  '{9'h000, 9'h001, 9'h002, 9'h028, 9'h003, 9'h000}};
        e_dep = '{'{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0},
                  '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0},
                  '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0}};
        for (int s = 0; s < 3; s++) begin
            load_program();
            ir = s_ir[s]; zf = s_zf[s]; rdy = 1'b1;
            apply_reset();
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                n_cmp++;
                if (upc !== e_upc[s][i] || stk_depth !== e_dep[s][i]) begin
                    n_bad++;
                    $display("FAIL dispatch_s%0d_step%0d: upc=%h depth=%0d want %h/%0d",
                             s, i, upc, stk_depth, e_upc[s][i], e_dep[s][i]);
                end
            end
            $display("dispatch: scenario %0d ir=%h zf=%b checked", s, s_ir[s], s_zf[s]);
        end
    endtask

    task automatic test_undecoded();
        logic [8:0] e_addr;
        logic       e_ill;
        logic [8:0] e_upc1;
        logic [2:0] e_dep1;
`ifdef USEQ_TRAP_EN
        e_addr = 9'h1ff; e_ill = 1'b1; e_upc1 = 9'h1ff; e_dep1 = 3'd1;
`else
        e_addr = 9'h000; e_ill = 1'b0; e_upc1 = 9'h000; e_dep1 = 3'd0;
`endif
        load_program();
        ir = 16'o000000; zf = 1'b0; rdy = 1'b1;
        apply_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (upc !== 9'h002 || uaddr !== e_addr || ill_op !== e_ill) begin
            n_bad++;
            $display("FAIL undecoded_cip: upc=%h uaddr=%h ill=%b want 002/%h/%b",
                     upc, uaddr, ill_op, e_addr, e_ill);
        end
        @(negedge clk);
        n_cmp++;
        if (upc !== e_upc1 || stk_depth !== e_dep1 || ill_op !== 1'b0) begin
            n_bad++;
            $display("FAIL undecoded_next: upc=%h depth=%0d ill=%b want %h/%0d/0",
                     upc, stk_depth, ill_op, e_upc1, e_dep1);
        end
        $display("undecoded: done");
    endtask

    task automatic test_overflow();
        logic [8:0] e_upc [5];
        logic [2:0] e_dep [5];
        load_program();
        rom_flow[9'h000] = CSD;
        rom_flow[9'h100] = CSD;
        ir = 16'o000000; zf = 1'b0; rdy = 1'b1;
        apply_reset();
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (upc !== 9'h100 || stk_depth !== ((k < 4) ? 3'(k) : 3'd4) || stk_err !== (k >= 5)) begin
                n_bad++;
                $display("FAIL overflow_push%0d: upc=%h depth=%0d err=%b want 100/%0d/%b",
                         k, upc, stk_depth, stk_err, (k < 4) ? k : 4, (k >= 5));
            end
        end
        // Unwind: entries are 001,101,101,101 from bottom to top.
        rom_flow[9'h100] = RET;
        rom_flow[9'h101] = RET;
        rom_flow[9'h001] = RET;
        e_upc = '{9'h101, 9'h101, 9'h101, 9'h001, 9'h000};
        e_dep = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (upc !== e_upc[i] || stk_depth !== e_dep[i] || stk_err !== 1'b1) begin
                n_bad++;
                $display("FAIL overflow_pop%0d: upc=%h depth=%0d err=%b want %h/%0d/1",
                         i, upc, stk_depth, stk_err, e_upc[i], e_dep[i]);
            end
        end
        $display("overflow: done");
    endtask

    task automatic test_ret_empty();
        load_program();
        rom_flow[9'h000] = RET;
        ir = 16'h0000; zf = 1'b0; rdy = 1'b1;
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (uaddr !== 9'h000 || stk_err !== 1'b0 || stk_depth !== 3'd0) begin
            n_bad++;
            $display("FAIL ret_empty_addr: uaddr=%h err=%b depth=%0d want 000/0/0", uaddr, stk_err, stk_depth);
        end
        @(negedge clk);
        n_cmp++;
        if (stk_err !== 1'b1 || upc !== 9'h000 || stk_depth !== 3'd0) begin
            n_bad++;
            $display("FAIL ret_empty_err: err=%b upc=%h depth=%0d want 1/000/0", stk_err, upc, stk_depth);
        end
        $display("ret_empty: done");
    endtask

    task automatic test_reset_mid();
        load_program();
        ir = 16'o010102; zf = 1'b0; rdy = 1'b1;
        apply_reset();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (upc !== 9'h100 || stk_depth !== 3'd2) begin
            n_bad++;
            $display("FAIL mid_setup: upc=%h depth=%0d want 100/2", upc, stk_depth);
        end
        rdy = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (uaddr !== 9'h000) begin
            n_bad++;
            $display("FAIL mid_uaddr: uaddr=%h want 000", uaddr);
        end
        @(negedge clk);
        n_cmp++;
        if (upc !== 9'h000 || stk_depth !== 3'd0 || uvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: upc=%h depth=%0d uvalid=%b want 000/0/0", upc, stk_depth, uvalid);
        end
        reset_n = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (upc !== 9'h001 || stk_depth !== 3'd0 || uvalid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_restart: upc=%h depth=%0d uvalid=%b want 001/0/1", upc, stk_depth, uvalid);
        end
        $display("reset_mid: done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_n = 1'b0;
        ir = 16'h0000;
        zf = 1'b0;
        rdy = 1'b1;
        test_reset();
        test_mov();
        test_autoinc_stall();
        test_dispatch();
        test_undecoded();
        test_overflow();
        test_ret_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
